adc_read_master: RTL and testbench
==================================

Name: adc_read_master

Overview:
- SPI master that reads one conversion from an external (or simulated) ADC each time it is armed.
- Drives ss_L and sck, waits a fixed conversion time, then shifts WID bits MSB-first from miso.
- Delivers the word sign-extended to OUT_WID bits with an arm/finished level handshake.
- Sits directly downstream of the ADC SPI slave and upstream of the control-loop error computation.

Parameters:
- WID, 18, ADC word width in bits.
- WID_LEN, 5, width of the internal bit counter; must satisfy 2^WID_LEN > WID.
- OUT_WID, 32, width of data_out; must be >= WID.
- POLARITY, 1, sck idle level.
- PHASE, 0, sampling edge: 0 = miso sampled on the leading edge of each sck period, 1 = on the trailing edge.
- SCK_HALF, 2, clk cycles per sck half-period; must be >= 1.
- SCK_HALF_WID, 3, counter width for SCK_HALF.
- CONV_WAIT, 4, clk cycles from ss_L falling to the first sck edge; 0 is allowed.
- CONV_WAIT_WID, 4, counter width for CONV_WAIT.

Ports:
- clk, in, 1, system clock.
- rst_L, in, 1, asynchronous active-low reset.
- arm, in, 1, level request to perform one read.
- finished, out, 1, high while a completed word is held on data_out.
- busy, out, 1, high from ss_L falling until finished rises.
- data_out, out, OUT_WID, last read word, sign-extended from bit WID-1.
- miso, in, 1, serial data from the ADC.
- sck, out, 1, SPI clock.
- ss_L, out, 1, active-low slave select; its falling edge starts the conversion.

Behaviour:
- Reset (rst_L=0, asynchronous): state IDLE, ss_L=1, sck=POLARITY, finished=0, busy=0, data_out=0, all counters and shift register cleared.
  - Reset asserted mid-transfer aborts it immediately; the partial word is discarded and no finished pulse occurs.
- States: IDLE, CONV, SHIFT, DONE.
- IDLE: on a clk edge with arm=1, go to CONV. ss_L=0 and busy=1 from that edge.
- CONV: hold sck=POLARITY for CONV_WAIT cycles, then go to SHIFT. With CONV_WAIT=0, go to SHIFT on the next edge.
- SHIFT:
  - Generate exactly WID sck periods.
  - Each half-period lasts SCK_HALF clk cycles; the leading half toggles sck away from POLARITY, the trailing half returns it.
  - Sample miso into the shift register (MSB first) at the clk edge that produces the sampling sck edge selected by PHASE.
  - The bit counter counts sampled bits 0..WID-1.
  - After the trailing edge of period WID plus one further SCK_HALF hold, go to DONE.
- DONE, on entry edge:
  - ss_L=1, busy=0, finished=1.
  - data_out = shift register sign-extended ({(OUT_WID-WID){sr[WID-1]}, sr}).
  - Hold all outputs while arm=1.
  - When arm=0, go to IDLE and set finished=0 on that edge.
- arm held high through DONE never starts a second read; a new read requires arm low for at least one cycle, then high.
- arm dropped during CONV or SHIFT is ignored; the transfer completes and finished rises, then falls on the next cycle because arm=0.
- data_out changes only on entry to DONE and on reset; it holds its value through IDLE, CONV and SHIFT.
- sck is always POLARITY while ss_L=1.
- No glitches: sck and ss_L are driven directly from flops.
- OUT_WID == WID: no extension.

Decomposition:
- Shared package: state encoding (IDLE/CONV/SHIFT/DONE) and a sign-extension width helper constant, reused by the DAC write master.
- One natural sub-module: spi_master_clkgen. It generates the sck level plus leading/trailing edge strobes from SCK_HALF, POLARITY and PHASE, and is enabled by the FSM.
- Bit counting and shifting stay in the top.

Test Plan:
- Defaults; slave model returns 18'h1FFFF → finished after 4 + 18×4 + 2 clk cycles, data_out=32'h0001FFFF, exactly 18 sck rising and 18 falling edges, ss_L low throughout.
- Slave returns 18'h20001 → data_out=32'hFFFE0001. Repeat with 18'h2A5A5 → 32'hFFFEA5A5.
- PHASE=1, POLARITY=0, slave shifting on the leading edge, pattern 18'h15A5A → data_out=32'h00015A5A; sck idles low before and after.
- arm held high 200 cycles → exactly one ss_L low window and one finished rise. Drop arm → finished=0 next cycle; re-arm → second read with new value 18'h00003 → 32'h00000003.
- rst_L pulsed low after bit 7 → same cycle ss_L=1, sck=POLARITY, busy=0, data_out=0. After release with arm=1, a full clean read completes.
- CONV_WAIT=0, SCK_HALF=1 → first sck edge one cycle after ss_L falls; word still captured correctly (18'h0AAAA → 32'h0000AAAA).

Source files
------------

// File: rtl/adc_read_master_pkg.sv
// Shared definitions for the SPI read/write masters: FSM state encoding and
// the sign-extension pad width helper.
package adc_read_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } spi_state_t;

    // Number of copied sign bits needed to widen a wid-bit word to out_wid bits.
    function automatic int sext_pad(input int out_wid, input int wid);
        return out_wid - wid;
    endfunction

endpackage

// File: rtl/adc_read_master_clkgen.sv
// SPI clock generator: while enabled, toggles sck every SCK_HALF clk cycles
// starting on the first enabled edge, and flags which toggles are leading/trailing.
module spi_master_clkgen #(
    parameter int SCK_HALF     = 2,
    parameter int SCK_HALF_WID = 3,
    parameter int POLARITY     = 1
) (
    input  logic clk,
    input  logic rst_L,
    input  logic en,
    output logic sck,
    output logic lead_stb,
    output logic trail_stb
);

    localparam logic [SCK_HALF_WID-1:0] HALF_LAST = SCK_HALF_WID'(SCK_HALF - 1);
    localparam logic                    IDLE_LVL  = (POLARITY != 0);

    logic [SCK_HALF_WID-1:0] half_cnt_reg, half_cnt_next;
    logic                    sck_reg, sck_next;
    logic                    trail_due_reg, trail_due_next;
    logic                    tick;

    // Strobes describe the sck edge that the coming clk edge will produce.
    assign tick      = en && (half_cnt_reg == '0);
    assign lead_stb  = tick && !trail_due_reg;
    assign trail_stb = tick && trail_due_reg;
    assign sck       = sck_reg;

    always_comb begin
        half_cnt_next  = half_cnt_reg;
        sck_next       = sck_reg;
        trail_due_next = trail_due_reg;
        if (!en) begin
            half_cnt_next  = '0;
            sck_next       = IDLE_LVL;
            trail_due_next = 1'b0;
        end else if (tick) begin
            half_cnt_next  = HALF_LAST;
            sck_next       = ~sck_reg;
            trail_due_next = ~trail_due_reg;
        end else begin
            half_cnt_next  = half_cnt_reg - SCK_HALF_WID'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            half_cnt_reg  <= '0;
            sck_reg       <= IDLE_LVL;
            trail_due_reg <= 1'b0;
        end else begin
            half_cnt_reg  <= half_cnt_next;
            sck_reg       <= sck_next;
            trail_due_reg <= trail_due_next;
        end
    end

endmodule

// File: rtl/adc_read_master.sv
// SPI master that performs one ADC conversion read per arm request and holds
// the sign-extended result with a finished/arm level handshake.
module adc_read_master
    import adc_read_master_pkg::*;
#(
    parameter int WID           = 18,
    parameter int WID_LEN       = 5,
    parameter int OUT_WID       = 32,
    parameter int POLARITY      = 1,
    parameter int PHASE         = 0,
    parameter int SCK_HALF      = 2,
    parameter int SCK_HALF_WID  = 3,
    parameter int CONV_WAIT     = 4,
    parameter int CONV_WAIT_WID = 4
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               arm,
    output logic               finished,
    output logic               busy,
    output logic [OUT_WID-1:0] data_out,
    input  logic               miso,
    output logic               sck,
    output logic               ss_L
);

    localparam int                    PAD_W     = sext_pad(OUT_WID, WID);
    localparam logic [WID_LEN-1:0]    LAST_CNT  = WID_LEN'((PHASE != 0) ? WID - 1 : WID);
    localparam logic [SCK_HALF_WID:0] TAIL_LOAD = (SCK_HALF_WID + 1)'(2 * SCK_HALF - 1);

    spi_state_t                state_reg, state_next;
    logic [CONV_WAIT_WID-1:0]  conv_cnt_reg, conv_cnt_next;
    logic [WID_LEN-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [WID-1:0]            sr_reg, sr_next;
    logic                      tail_reg, tail_next;
    logic [SCK_HALF_WID:0]     tail_cnt_reg, tail_cnt_next;
    logic                      ss_L_reg, ss_L_next;
    logic                      busy_reg, busy_next;
    logic                      finished_reg, finished_next;
    logic [OUT_WID-1:0]        data_reg, data_next;
    logic [OUT_WID-1:0]        ext_word;
    logic                      conv_last, clk_en, lead_stb, trail_stb, sample_stb, last_trail;

    generate
        if (PAD_W > 0) begin : g_sext
            assign ext_word = {{PAD_W{sr_reg[WID-1]}}, sr_reg};
        end else begin : g_noext
            assign ext_word = sr_reg;
        end
    endgenerate

    // The clock generator is enabled one cycle early so the first sck edge
    // coincides with the CONV -> SHIFT edge.
    assign conv_last  = (CONV_WAIT <= 1) ||
                        (conv_cnt_reg == CONV_WAIT_WID'(CONV_WAIT - 1));
    assign clk_en     = ((state_reg == ST_CONV) && conv_last) ||
                        ((state_reg == ST_SHIFT) && !tail_reg);
    assign sample_stb = (PHASE != 0) ? trail_stb : lead_stb;
    assign last_trail = trail_stb && (bit_cnt_reg == LAST_CNT);

    spi_master_clkgen #(
        .SCK_HALF     (SCK_HALF),
        .SCK_HALF_WID (SCK_HALF_WID),
        .POLARITY     (POLARITY)
    ) u_clkgen (
        .clk       (clk),
        .rst_L     (rst_L),
        .en        (clk_en),
        .sck       (sck),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    always_comb begin
        state_next    = state_reg;
        conv_cnt_next = conv_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        sr_next       = sr_reg;
        tail_next     = tail_reg;
        tail_cnt_next = tail_cnt_reg;
        ss_L_next     = ss_L_reg;
        busy_next     = busy_reg;
        finished_next = finished_reg;
        data_next     = data_reg;

        if (sample_stb) begin
            sr_next      = {sr_reg[WID-2:0], miso};
            bit_cnt_next = bit_cnt_reg + WID_LEN'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (arm) begin
                    state_next    = ST_CONV;
                    ss_L_next     = 1'b0;
                    busy_next     = 1'b1;
                    conv_cnt_next = '0;
                    bit_cnt_next  = '0;
                    sr_next       = '0;
                    tail_next     = 1'b0;
                    tail_cnt_next = '0;
                end
            end
            ST_CONV: begin
                conv_cnt_next = conv_cnt_reg + CONV_WAIT_WID'(1);
                if (conv_last) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Tail: the last trailing half plus one more half-period of hold.
                if (tail_reg) begin
                    if (tail_cnt_reg == '0) begin
                        state_next    = ST_DONE;
                        ss_L_next     = 1'b1;
                        busy_next     = 1'b0;
                        finished_next = 1'b1;
                        data_next     = ext_word;
                    end else begin
                        tail_cnt_next = tail_cnt_reg - (SCK_HALF_WID + 1)'(1);
                    end
                end else if (last_trail) begin
                    tail_next     = 1'b1;
                    tail_cnt_next = TAIL_LOAD;
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_next    = ST_IDLE;
                    finished_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg    <= ST_IDLE;
            conv_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            sr_reg       <= '0;
            tail_reg     <= 1'b0;
            tail_cnt_reg <= '0;
            ss_L_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            conv_cnt_reg <= conv_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            sr_reg       <= sr_next;
            tail_reg     <= tail_next;
            tail_cnt_reg <= tail_cnt_next;
            ss_L_reg     <= ss_L_next;
            busy_reg     <= busy_next;
            finished_reg <= finished_next;
            data_reg     <= data_next;
        end
    end

    assign ss_L     = ss_L_reg;
    assign busy     = busy_reg;
    assign finished = finished_reg;
    assign data_out = data_reg;

endmodule

// File: tb/tb_adc_read_master.sv
// Bench for adc_read_master: three configurations, each read from a behavioural
// ADC slave and checked against word, latency and sck-edge expectations.
module tb_adc_read_master;

    logic clk = 1'b0;
    logic rst_L;
    logic arm  [3];
    logic miso [3];
    wire        finished_w [3];
    wire        busy_w     [3];
    wire        sck_w      [3];
    wire        ss_w       [3];
    wire [31:0] dout_w     [3];

    // Per-instance configuration: PHASE, POLARITY, CONV_WAIT, SCK_HALF.
    int ph_t  [3] = '{0, 1, 0};
    int pol_t [3] = '{1, 0, 1};
    int cw_t  [3] = '{4, 4, 0};
    int h_t   [3] = '{2, 2, 1};

    logic [31:0] last_exp [3];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adc_read_master u_dut0 (
        .clk(clk), .rst_L(rst_L), .arm(arm[0]), .finished(finished_w[0]), .busy(busy_w[0]),
        .data_out(dout_w[0]), .miso(miso[0]), .sck(sck_w[0]), .ss_L(ss_w[0]));

    adc_read_master #(.POLARITY(0), .PHASE(1)) u_dut1 (
        .clk(clk), .rst_L(rst_L), .arm(arm[1]), .finished(finished_w[1]), .busy(busy_w[1]),
        .data_out(dout_w[1]), .miso(miso[1]), .sck(sck_w[1]), .ss_L(ss_w[1]));

    adc_read_master #(.CONV_WAIT(0), .SCK_HALF(1)) u_dut2 (
        .clk(clk), .rst_L(rst_L), .arm(arm[2]), .finished(finished_w[2]), .busy(busy_w[2]),
        .data_out(dout_w[2]), .miso(miso[2]), .sck(sck_w[2]), .ss_L(ss_w[2]));

    // One read on instance k with the slave returning w; leaves arm high.
    task automatic run_read(input int k, input logic [17:0] w, input string tag);
        logic [31:0] exp_d;
        int cyc, c_ss, c_first, c_fin, idx, rises, falls, lat_exp, first_exp;
        logic prev_ss, prev_sck, ss_broken, idle_bad, pol;
        pol       = (pol_t[k] != 0);
        exp_d     = 32'($signed(w));
        first_exp = (cw_t[k] > 0) ? cw_t[k] : 1;
        lat_exp   = first_exp + 2 * h_t[k] * 18 + h_t[k];
        cyc = 0; c_ss = -1; c_first = -1; c_fin = -1; idx = 17; rises = 0; falls = 0;
        ss_broken = 1'b0; idle_bad = 1'b0;
        prev_ss = ss_w[k]; prev_sck = sck_w[k];
        miso[k] = 1'b0;
        arm[k]  = 1'b1;
        while (c_fin < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ss_w[k] && (sck_w[k] !== pol)) idle_bad = 1'b1;
            if (prev_ss && !ss_w[k] && c_ss < 0) begin
                c_ss = cyc;
                idx  = 17;
                if (ph_t[k] == 0) miso[k] = w[idx];
            end
            if (sck_w[k] !== prev_sck) begin
                if (c_first < 0) c_first = cyc;
                if (sck_w[k]) rises++; else falls++;
                if (sck_w[k] != pol) begin
                    if (ph_t[k] == 1 && idx >= 0) begin
                        miso[k] = w[idx];
                        idx--;
                    end
                end else if (ph_t[k] == 0) begin
                    idx--;
                    if (idx >= 0) miso[k] = w[idx];
                end
            end
            if (finished_w[k] === 1'b1) c_fin = cyc;
            else if (c_ss >= 0 && ss_w[k] !== 1'b0) ss_broken = 1'b1;
            prev_ss  = ss_w[k];
            prev_sck = sck_w[k];
        end
        $display("read %s inst=%0d word=%05h data_out=%08h cycles=%0d", tag, k, w, dout_w[k], c_fin - c_ss);
        n_cmp++;
        if (c_fin < 0 || c_ss < 0 || (c_fin - c_ss) != lat_exp) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (ss %0d fin %0d) expected %0d", tag, c_fin - c_ss, c_ss, c_fin, lat_exp);
        end
        n_cmp++;
        if (dout_w[k] !== exp_d) begin
            n_fail++;
            $display("FAIL %s data_out: got %08h expected %08h", tag, dout_w[k], exp_d);
        end
        n_cmp++;
        if (rises != 18 || falls != 18) begin
            n_fail++;
            $display("FAIL %s sck_edges: got %0d rises %0d falls expected 18/18", tag, rises, falls);
        end
        n_cmp++;
        if (ss_broken || idle_bad) begin
            n_fail++;
            $display("FAIL %s ss_window: got broken=%0b idle_sck_bad=%0b expected 0/0", tag, ss_broken, idle_bad);
        end
        n_cmp++;
        if (c_first - c_ss != first_exp) begin
            n_fail++;
            $display("FAIL %s first_sck: got %0d expected %0d", tag, c_first - c_ss, first_exp);
        end
        n_cmp++;
        if (ss_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_outputs: got ss_L=%b busy=%b expected 1/0", tag, ss_w[k], busy_w[k]);
        end
        last_exp[k] = exp_d;
    endtask

    // Drop arm: finished must fall on the next edge while data_out holds.
    task automatic release_arm(input int k, input string tag);
        arm[k] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (finished_w[k] !== 1'b0 || ss_w[k] !== 1'b1 || dout_w[k] !== last_exp[k]) begin
            n_fail++;
            $display("FAIL %s release: got finished=%b ss_L=%b data=%08h expected 0/1/%08h",
                     tag, finished_w[k], ss_w[k], dout_w[k], last_exp[k]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        for (int k = 0; k < 3; k++) begin
            arm[k] = 1'b0; miso[k] = 1'b0; last_exp[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ss_w[k] !== 1'b1 || sck_w[k] !== (pol_t[k] != 0) || finished_w[k] !== 1'b0 ||
                busy_w[k] !== 1'b0 || dout_w[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got ss_L=%b sck=%b fin=%b busy=%b data=%08h expected 1/%0d/0/0/0",
                         k, ss_w[k], sck_w[k], finished_w[k], busy_w[k], dout_w[k], pol_t[k]);
            end
        end
        rst_L = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_default();
        logic [17:0] pats [6];
        pats[0] = 18'h1FFFF; pats[1] = 18'h20001; pats[2] = 18'h2A5A5;
        for (int i = 3; i < 6; i++) pats[i] = 18'($urandom_range(0, 18'h3FFFF));
        for (int i = 0; i < 6; i++) begin
            run_read(0, pats[i], "default");
            release_arm(0, "default");
        end
    endtask

    task automatic test_phase1();
        logic [17:0] pats [3];
        pats[0] = 18'h15A5A;
        for (int i = 1; i < 3; i++) pats[i] = 18'($urandom_range(0, 18'h3FFFF));
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sck_w[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL phase1 idle_before: got sck=%b expected 0", sck_w[1]);
            end
            run_read(1, pats[i], "phase1");
            release_arm(1, "phase1");
            n_cmp++;
            if (sck_w[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL phase1 idle_after: got sck=%b expected 0", sck_w[1]);
            end
        end
    endtask

    task automatic test_fast();
        logic [17:0] pats [3];
        pats[0] = 18'h0AAAA;
        for (int i = 1; i < 3; i++) pats[i] = 18'($urandom_range(0, 18'h3FFFF));
        for (int i = 0; i < 3; i++) begin
            run_read(2, pats[i], "fast");
            release_arm(2, "fast");
        end
    endtask

    task automatic test_arm_hold();
        int ss_falls, fin_drops;
        logic prev_ss;
        run_read(0, 18'($urandom_range(0, 18'h3FFFF)), "hold");
        ss_falls = 0; fin_drops = 0; prev_ss = ss_w[0];
        repeat (200 - 78) begin
            @(negedge clk);
            if (prev_ss && !ss_w[0]) ss_falls++;
            if (finished_w[0] !== 1'b1) fin_drops++;
            prev_ss = ss_w[0];
        end
        $display("hold: extra ss_L falls=%0d finished drops=%0d", ss_falls, fin_drops);
        n_cmp++;
        if (ss_falls != 0 || fin_drops != 0) begin
            n_fail++;
            $display("FAIL hold single_read: got %0d extra windows %0d finished drops expected 0/0", ss_falls, fin_drops);
        end
        release_arm(0, "hold");
        run_read(0, 18'h00003, "rearm");
        release_arm(0, "rearm");
    endtask

    task automatic test_reset_mid();
        int leads, cyc;
        logic prev_sck;
        leads = 0; cyc = 0; prev_sck = sck_w[0];
        arm[0] = 1'b1;
        miso[0] = 1'b1;
        while (leads < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (prev_sck && !sck_w[0]) leads++;
            prev_sck = sck_w[0];
        end
        @(negedge clk);
        rst_L = 1'b0;
        #1;
        $display("mid-transfer reset after %0d sampled bits", leads);
        n_cmp++;
        if (leads != 8 || ss_w[0] !== 1'b1 || sck_w[0] !== 1'b1 || busy_w[0] !== 1'b0 ||
            dout_w[0] !== 32'h0 || finished_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got bits=%0d ss_L=%b sck=%b busy=%b fin=%b data=%08h expected 8/1/1/0/0/0",
                     leads, ss_w[0], sck_w[0], busy_w[0], finished_w[0], dout_w[0]);
        end
        @(negedge clk);
        rst_L = 1'b1;
        run_read(0, 18'($urandom_range(0, 18'h3FFFF)), "post_reset");
        release_arm(0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_default();
        test_phase1();
        test_fast();
        test_arm_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
